radix4_control_unit: RTL

RADIX4_CONTROL_UNIT -- requirements
Module: radix4_control_unit

---
 rtl/radix4_control_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/radix4_control_unit.sv
// Control sequencer for a radix-4 (modified Booth) multiplier.
// Walks the datapath through load, four decode/add-sub/shift iterations,
// and two output transfers. Every control line is registered from the
// state held at the sampling edge, so each pulse appears one edge after
// the corresponding state is entered.
module radix4_control_unit (
  input  logic clk,
  input  logic rst_b,
  input  logic bgn,
  input  logic q1,
  input  logic q0,
  input  logic q_1,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic c7,
  output logic c8,
  output logic busy,
  output logic stop
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_M = 4'd1,
    LOAD_Q = 4'd2,
    DECODE = 4'd3,
    ADD_M  = 4'd4,
    ADD_2M = 4'd5,
    SUB_M  = 4'd6,
    SUB_2M = 4'd7,
    SHIFT  = 4'd8,
    OUT_A  = 4'd9,
    OUT_Q  = 4'd10,
    DONE   = 4'd11
  } state_t;

  state_t     state;
  logic [1:0] cnt;

  // State sequencing, iteration counter and registered control decodes
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state <= IDLE;
      cnt   <= 2'd0;
      c0    <= 1'b0;
      c1    <= 1'b0;
      c2    <= 1'b0;
      c3    <= 1'b0;
      c4    <= 1'b0;
      c5    <= 1'b0;
      c6    <= 1'b0;
      c7    <= 1'b0;
      c8    <= 1'b0;
      busy  <= 1'b0;
      stop  <= 1'b0;
    end else begin
      // Output stage: one-hot decode of the state present at this edge
      c0   <= (state == LOAD_M);
      c1   <= (state == LOAD_Q);
      c2   <= (state == ADD_M);
      c3   <= (state == ADD_2M);
      c4   <= (state == SUB_M);
      c5   <= (state == SUB_2M);
      c6   <= (state == SHIFT);
      c7   <= (state == OUT_A);
      c8   <= (state == OUT_Q);
      busy <= (state != IDLE) && (state != DONE);
      stop <= (state == DONE);

      // Next-state stage
      case (state)
        IDLE: begin
          if (bgn) state <= LOAD_M;
        end
        LOAD_M: begin
          cnt   <= 2'd0;
          state <= LOAD_Q;
        end
        LOAD_Q: state <= DECODE;
        DECODE: begin
          // Booth recoding of the overlapping triple {Q[1],Q[0],Q[-1]}
          case ({q1, q0, q_1})
            3'b001, 3'b010: state <= ADD_M;
            3'b011:         state <= ADD_2M;
            3'b100:         state <= SUB_2M;
            3'b101, 3'b110: state <= SUB_M;
            default:        state <= SHIFT;
          endcase
        end
        ADD_M, ADD_2M, SUB_M, SUB_2M: state <= SHIFT;
        SHIFT: begin
          cnt   <= cnt + 2'd1;
          state <= (cnt == 2'd3) ? OUT_A : DECODE;
        end
        OUT_A: state <= OUT_Q;
        OUT_Q: state <= DONE;
        DONE: begin
          // Stay put until the requester drops bgn; no direct restart
          if (!bgn) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
